// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division, one bit
// per cycle. Every operation has a fixed WIDTH+2 cycle latency from start to done.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // op[1] selects divide, op[0] selects unsigned.
    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;
    logic                 neg_a_q, neg_a_d;
    logic                 neg_b_q, neg_b_d;
    logic                 dz_q, dz_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 in_neg_a, in_neg_b;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_rem_sh;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem;
    logic [WIDTH-1:0]     res_hi, res_lo;

    // Operand conditioning: magnitudes and sign flags for signed ops.
    always_comb begin
        in_neg_a = ~op[0] & a[WIDTH-1];
        in_neg_b = ~op[0] & b[WIDTH-1];
        abs_a    = in_neg_a ? (~a + 1'b1) : a;
        abs_b    = in_neg_b ? (~b + 1'b1) : b;
    end

    // One iteration of each algorithm. acc holds {upper, lower} working halves:
    // multiply keeps {partial product, remaining multiplier bits}, divide keeps
    // {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff   = div_rem_sh - {1'b0, opb_q};
        if (div_diff[WIDTH]) begin
            div_next = {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Final sign fix-up; negation wraps modulo 2^WIDTH so the MIN/-1 case falls out.
    always_comb begin
        prod = (~op_q[0] & (neg_a_q ^ neg_b_q)) ? (~acc_q + 1'b1) : acc_q;
        quot = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        if (!op_q[1]) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi = orig_a_q;
            res_lo = '1;
        end else begin
            res_hi = neg_a_q ? (~rem + 1'b1) : rem;
            res_lo = (neg_a_q ^ neg_b_q) ? (~quot + 1'b1) : quot;
        end
    end

    // Next-state: issue, iterate, commit; cancel aborts without touching HI/LO.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opb_d    = opb_q;
        orig_a_d = orig_a_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (!cancel) begin
                    if (start) begin
                        // start wins over same-cycle moves
                        state_d  = StCalc;
                        op_d     = op;
                        opb_d    = abs_b;
                        orig_a_d = a;
                        neg_a_d  = in_neg_a;
                        neg_b_d  = in_neg_b;
                        dz_d     = op[1] & (b == '0);
                        cnt_d    = '0;
                        acc_d    = {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        if (mthi) hi_d = wdata;
                        if (mtlo) lo_d = wdata;
                    end
                end
            end
            StCalc: begin
                if (cancel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    acc_d = op_q[1] ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StFix;
                        cnt_d   = '0;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!cancel) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            opb_q    <= '0;
            orig_a_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            orig_a_q <= orig_a_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
